divider_arbiter: RTL and testbench
==================================

# divider_arbiter

Two-port arbiter and sequencer that shares one multi-cycle divider (start/done handshake, WIDTH-bit dividend/divisor, quotient/remainder) between two requesters. Grants round-robin, intercepts divide-by-zero without issuing it, guards each divide with a watchdog timeout, and returns one tagged response on a shared valid/ready bus. It sits between the requesting datapath blocks and the divider core.

## Interface
- WIDTH, 4, operand/result width
- TIMEOUT, 15, max WAIT cycles before abort (1..255)

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_dividend, req0_divisor / req1_dividend, req1_divisor  in  WIDTH  operands
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester served (0/1)
- rsp_quotient, rsp_remainder  out  WIDTH  result
- rsp_err  out  2  00 ok, 01 divide-by-zero, 10 timeout
- div_start  out  1  one-cycle start pulse to divider
- div_dividend, div_divisor  out  WIDTH  operands to divider, registered
- div_done  in  1  divider result valid (single cycle)
- div_quotient, div_remainder  in  WIDTH  divider result

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant = sole valid requester; if both valid, requester != last_served. reqN_ready = (state==IDLE) && grant==N && reqN_valid, combinational. On handshake: capture operands and id; divisor==0 -> RESP with err=01, quotient={WIDTH{1}}, remainder=dividend; else -> ISSUE.
- ISSUE: div_start=1 for exactly this cycle; div_dividend/div_divisor hold captured operands from ISSUE through end of WAIT. -> WAIT, timer=0.
- WAIT: timer increments each cycle. div_done=1 -> capture div_quotient/div_remainder, err=00, -> RESP. timer==TIMEOUT-1 and no done -> err=10, quotient=0, remainder=0, -> RESP. done and timeout same cycle: done wins.
- RESP: rsp_valid=1, rsp_* stable until rsp_ready=1; on handshake last_served=rsp_id, -> IDLE.
- div_done outside WAIT ignored; no state change.
- Only one transaction in flight; requests not granted wait with valid held.

## Timing
- Reset (rst_n low at a rising edge): state=IDLE, last_served=1 (req0 wins first tie), timer=0, all outputs 0 (req*_ready=0 because both valid low or forced low during reset), rsp_err=00.
- Reset mid-transaction: aborts immediately; pending response lost; no div_start issued after reset.
- Accept at cycle T: div_start at T+1; WAIT from T+2; div_done at cycle D -> rsp_valid at D+1.
- Divide-by-zero accepted at T: rsp_valid at T+1, div_start never asserted.
- Timeout: WAIT entered T+2, rsp_valid with err=10 at T+2+TIMEOUT.
- After rsp handshake at cycle R, earliest next accept is R+1.
- Min divide turnaround (done in first WAIT cycle, rsp_ready held high): 4 cycles/request.

## Test plan
- Single req0 5/2, divider model done 3 cycles after start -> div_start one cycle after accept, rsp_id=0, quotient=2, remainder=1, err=00, rsp_valid exactly one cycle after div_done.
- req0 1/0 -> no div_start, next-cycle rsp quotient=15, remainder=1, err=01.
- Both requesting continuously (req0 7/3, req1 0/1) -> grants alternate 0,1,0,1 after reset; req1 results quotient=0, remainder=0.
- Divider model never returns done -> rsp err=10 at TIMEOUT cycles after WAIT entry, quotient=0, remainder=0; next request serviced normally; late div_done ignored.
- rsp_ready low for 5 cycles -> rsp_* stable, req*_ready stays 0, no new div_start.
- rst_n low during WAIT -> all outputs 0 next cycle, last_served=1; subsequent 15/15 gives quotient=1, remainder=0.

Source files
------------

// File: rtl/divider_arbiter.sv
// divider_arbiter: shares one multi-cycle divider between two requesters.
//   Round-robin grant on ties, divide-by-zero answered locally without
//   starting the divider, watchdog abort of a divide that never completes,
//   one tagged response at a time on a valid/ready bus.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   reqN_valid/ready/dividend/divisor  request channels (N = 0, 1)
//   rsp_valid/ready/id/quotient/remainder/err  response channel
//                                   (err: 00 ok, 01 divide-by-zero, 10 timeout)
//   div_start/dividend/divisor      to the divider core
//   div_done/quotient/remainder     from the divider core
module divider_arbiter #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_dividend,
    input  logic [WIDTH-1:0] req0_divisor,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_dividend,
    input  logic [WIDTH-1:0] req1_divisor,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_quotient,
    output logic [WIDTH-1:0] rsp_remainder,
    output logic [1:0]       rsp_err,
    output logic             div_start,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_DZ  = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;

    state_t           state, state_nx;
    logic             last_served;
    logic             cur_id;
    logic [7:0]       timer;
    logic [WIDTH-1:0] opa_q, opb_q, quo_q, rem_q;
    logic [1:0]       err_q;

    logic             grant;
    logic             accept;
    logic             timeout_hit;
    logic [WIDTH-1:0] sel_a, sel_b;

    // Tie goes to whoever was not served last; otherwise the sole requester.
    always_comb begin
        if (req0_valid && req1_valid) grant = ~last_served;
        else                          grant = req1_valid;
    end

    // Ready is forced low while reset is asserted so nothing is accepted
    // in a cycle whose edge will clear the state anyway.
    assign req0_ready = rst_n && (state == IDLE) && !grant && req0_valid;
    assign req1_ready = rst_n && (state == IDLE) &&  grant && req1_valid;
    assign accept     = req0_ready || req1_ready;

    assign sel_a = grant ? req1_dividend : req0_dividend;
    assign sel_b = grant ? req1_divisor  : req0_divisor;

    assign timeout_hit = (timer == 8'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept) state_nx = (sel_b == '0) ? RESP : ISSUE;
            ISSUE: state_nx = WAIT;
            // done takes priority; either way the response goes out next
            WAIT:  if (div_done || timeout_hit) state_nx = RESP;
            RESP:  if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_served <= 1'b1;
            cur_id      <= 1'b0;
            timer       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            err_q       <= ERR_OK;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur_id <= grant;
                        opa_q  <= sel_a;
                        opb_q  <= sel_b;
                        if (sel_b == '0) begin
                            quo_q <= '1;
                            rem_q <= sel_a;
                            err_q <= ERR_DZ;
                        end
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    timer <= timer + 8'd1;
                    if (div_done) begin
                        quo_q <= div_quotient;
                        rem_q <= div_remainder;
                        err_q <= ERR_OK;
                    end else if (timeout_hit) begin
                        quo_q <= '0;
                        rem_q <= '0;
                        err_q <= ERR_TMO;
                    end
                end
                RESP: if (rsp_ready) last_served <= cur_id;
                default: ;
            endcase
        end
    end

    assign div_start     = (state == ISSUE);
    assign div_dividend  = opa_q;
    assign div_divisor   = opb_q;
    assign rsp_valid     = (state == RESP);
    assign rsp_id        = cur_id;
    assign rsp_quotient  = quo_q;
    assign rsp_remainder = rem_q;
    assign rsp_err       = err_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: transaction-level reference model checked
// every cycle, a reactive divider model, directed scenarios with literal
// expectations, then a randomized phase.
module tb_divider_arbiter;
    localparam int W  = 4;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst_n;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_dividend, req0_divisor, req1_dividend, req1_divisor;
    logic rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_quotient, rsp_remainder;
    logic [1:0] rsp_err;
    logic div_start, div_done;
    logic [W-1:0] div_dividend, div_divisor, div_quotient, div_remainder;

    always #5 clk = ~clk;

    divider_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_err(rsp_err),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
    endtask

    // ---------------- divider model ----------------
    int div_lat = 1;      // cycles from start to done; 0 = never
    bit spur_en = 0;
    int spur_req = 0;

    initial begin
        int cnt, spur_seen;
        logic st;
        logic [W-1:0] a, b;
        cnt = 0; spur_seen = 0;
        div_done = 1'b0; div_quotient = '0; div_remainder = '0;
        forever begin
            @(negedge clk);
            st = div_start; a = div_dividend; b = div_divisor;
            @(posedge clk); #1;
            div_done = 1'b0;
            if (st) cnt = div_lat;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    div_done      = 1'b1;
                    div_quotient  = (b != 0) ? a / b : '1;
                    div_remainder = (b != 0) ? a % b : a;
                end
            end else if (spur_req != spur_seen || (spur_en && $urandom_range(0, 15) == 0)) begin
                spur_seen     = spur_req;
                div_done      = 1'b1;
                div_quotient  = W'($urandom);
                div_remainder = W'($urandom);
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    // One transaction at a time, described by its accept cycle: start one
    // cycle later, waiting from two cycles later until done or the watchdog
    // deadline, then a response held until taken.
    int  cyc = 0;
    bit  m_live = 0, m_rstd = 0, m_txn = 0, m_rsp = 0, m_zero = 0, m_last = 1, m_id = 0;
    int  m_tacc = 0;
    logic [W-1:0] m_a, m_b, m_q, m_r;
    logic [1:0]   m_err;

    int n_acc = 0, n_rsp = 0, n_starts = 0, n_rv = 0, n_hs0 = 0, n_hs1 = 0;
    int t_acc = 0, t_start = 0, t_rv = 0, t_done = 0;
    bit gid_q[$];
    logic [W-1:0] l_q, l_r;
    logic [1:0] l_err;
    bit l_id, prev_rv = 0;

    initial begin
        bit g1, e_r0, e_r1, e_st, e_wt;
        forever begin
            @(negedge clk);
            cyc++;
            g1   = (req0_valid && req1_valid) ? !m_last : req1_valid;
            e_r0 = rst_n && !m_txn && req0_valid && !g1;
            e_r1 = rst_n && !m_txn && req1_valid && g1;
            e_st = m_txn && !m_zero && (cyc == m_tacc + 1);
            e_wt = m_txn && !m_zero && !m_rsp && (cyc >= m_tacc + 2);

            if (div_start === 1'b1) begin n_starts++; t_start = cyc; end
            if (div_done) t_done = cyc;
            if (rsp_valid === 1'b1 && !prev_rv) begin n_rv++; t_rv = cyc; end
            prev_rv = (rsp_valid === 1'b1);
            if (req0_valid && req0_ready === 1'b1) n_hs0++;
            if (req1_valid && req1_ready === 1'b1) n_hs1++;
            if ((req0_valid && req0_ready === 1'b1) || (req1_valid && req1_ready === 1'b1)) begin
                n_acc++; t_acc = cyc; gid_q.push_back(req1_ready);
            end
            if (rsp_valid === 1'b1 && rsp_ready) begin
                n_rsp++; l_q = rsp_quotient; l_r = rsp_remainder; l_err = rsp_err; l_id = rsp_id;
            end

            if (m_live) begin
                chk("req0_ready", 32'(req0_ready), 32'(e_r0));
                chk("req1_ready", 32'(req1_ready), 32'(e_r1));
                chk("div_start",  32'(div_start),  32'(e_st));
                chk("rsp_valid",  32'(rsp_valid),  32'(m_rsp));
                if (m_rsp) begin
                    chk("rsp_id",        32'(rsp_id),        32'(m_id));
                    chk("rsp_quotient",  32'(rsp_quotient),  32'(m_q));
                    chk("rsp_remainder", 32'(rsp_remainder), 32'(m_r));
                    chk("rsp_err",       32'(rsp_err),       32'(m_err));
                end
                if (e_st || e_wt) begin
                    chk("div_dividend", 32'(div_dividend), 32'(m_a));
                    chk("div_divisor",  32'(div_divisor),  32'(m_b));
                end
                if (m_rstd) begin
                    chk("rst_rsp_id",   32'(rsp_id),        0);
                    chk("rst_rsp_q",    32'(rsp_quotient),  0);
                    chk("rst_rsp_r",    32'(rsp_remainder), 0);
                    chk("rst_rsp_err",  32'(rsp_err),       0);
                    chk("rst_div_a",    32'(div_dividend),  0);
                    chk("rst_div_b",    32'(div_divisor),   0);
                end
            end

            // advance the model across the coming edge
            if (!rst_n) begin
                m_live = 1; m_rstd = 1; m_txn = 0; m_rsp = 0; m_last = 1;
            end else begin
                m_rstd = 0;
                if (!m_txn) begin
                    if (e_r0 || e_r1) begin
                        m_txn = 1; m_tacc = cyc; m_id = e_r1;
                        m_a = e_r1 ? req1_dividend : req0_dividend;
                        m_b = e_r1 ? req1_divisor  : req0_divisor;
                        m_zero = (m_b == 0);
                        if (m_zero) begin m_rsp = 1; m_q = '1; m_r = m_a; m_err = 2'b01; end
                    end
                end else if (m_rsp) begin
                    if (rsp_ready) begin m_txn = 0; m_rsp = 0; m_last = m_id; end
                end else if (e_wt) begin
                    if (div_done) begin
                        m_rsp = 1; m_q = div_quotient; m_r = div_remainder; m_err = 2'b00;
                    end else if (cyc == m_tacc + 1 + TO) begin
                        m_rsp = 1; m_q = '0; m_r = '0; m_err = 2'b10;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_acc(input int target);
        int i = 0;
        while (n_acc < target && i < 80) begin step(); i++; end
        if (n_acc < target) tmo("accept_wait");
    endtask

    task automatic wait_rsp(input int target);
        int i = 0;
        while (n_rsp < target && i < 80) begin step(); i++; end
        if (n_rsp < target) tmo("rsp_wait");
    endtask

    task automatic wait_rv(input int target);
        int i = 0;
        while (n_rv < target && i < 80) begin step(); i++; end
        if (n_rv < target) tmo("rsp_valid_wait");
    endtask

    task automatic run_one(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
        int ta, tr;
        ta = n_acc + 1; tr = n_rsp + 1;
        div_lat = lat; rsp_ready = 1'b1;
        if (id) begin req1_dividend = a; req1_divisor = b; req1_valid = 1'b1; end
        else    begin req0_dividend = a; req0_divisor = b; req0_valid = 1'b1; end
        wait_acc(ta);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(tr);
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, a0, r0, v0, p0, p1, tgt;
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_dividend = '0; req0_divisor = '0; req1_dividend = '0; req1_divisor = '0;
        repeat (3) step();
        chk("reset_req0_ready", 32'(req0_ready), 0);
        chk("reset_rsp_valid",  32'(rsp_valid),  0);
        rst_n = 1'b1;
        step();

        // 5/2, done three cycles after start
        run_one(0, 4'd5, 4'd2, 3);
        chk("t1_start_lat", 32'(t_start - t_acc), 1);
        chk("t1_rsp_after_done", 32'(t_rv - t_done), 1);
        chk("t1_id", 32'(l_id), 0);
        chk("t1_q", 32'(l_q), 2);
        chk("t1_r", 32'(l_r), 1);
        chk("t1_err", 32'(l_err), 0);

        // 1/0 answered locally
        s0 = n_starts;
        run_one(0, 4'd1, 4'd0, 3);
        chk("dz_no_start", 32'(n_starts - s0), 0);
        chk("dz_rsp_lat", 32'(t_rv - t_acc), 1);
        chk("dz_q", 32'(l_q), 15);
        chk("dz_r", 32'(l_r), 1);
        chk("dz_err", 32'(l_err), 1);

        // divider never answers -> watchdog
        run_one(1, 4'd9, 4'd2, 0);
        chk("to_rsp_lat", 32'(t_rv - t_acc), 32'(2 + TO));
        chk("to_q", 32'(l_q), 0);
        chk("to_r", 32'(l_r), 0);
        chk("to_err", 32'(l_err), 2);
        chk("to_id", 32'(l_id), 1);
        v0 = n_rv;
        spur_req++;
        repeat (3) step();
        chk("late_done_ignored", 32'(n_rv - v0), 0);
        run_one(0, 4'd6, 4'd3, 2);
        chk("after_to_q", 32'(l_q), 2);
        chk("after_to_err", 32'(l_err), 0);

        // done on the last waiting cycle wins; one later is a timeout
        run_one(0, 4'd13, 4'd4, TO);
        chk("edge_done_err", 32'(l_err), 0);
        chk("edge_done_q", 32'(l_q), 3);
        run_one(0, 4'd13, 4'd4, TO + 1);
        chk("edge_late_err", 32'(l_err), 2);

        // response back-pressure
        div_lat = 1; rsp_ready = 1'b0;
        req0_dividend = 4'd8; req0_divisor = 4'd3; req0_valid = 1'b1;
        tgt = n_rv + 1;
        wait_acc(n_acc + 1);
        req0_valid = 1'b0;
        req1_dividend = 4'd4; req1_divisor = 4'd2; req1_valid = 1'b1;
        wait_rv(tgt);
        s0 = n_starts; a0 = n_acc; r0 = n_rsp;
        repeat (5) step();
        chk("hold_no_start", 32'(n_starts - s0), 0);
        chk("hold_no_accept", 32'(n_acc - a0), 0);
        chk("hold_valid", 32'(rsp_valid), 1);
        chk("hold_q", 32'(rsp_quotient), 2);
        chk("hold_r", 32'(rsp_remainder), 2);
        rsp_ready = 1'b1;
        wait_acc(a0 + 1);
        req1_valid = 1'b0;
        wait_rsp(r0 + 2);
        chk("hold_next_id", 32'(l_id), 1);
        chk("hold_next_q", 32'(l_q), 2);

        // reset while waiting on the divider
        run_one(1, 4'd3, 4'd1, 1);          // leaves last_served = 1... then req0 runs
        div_lat = 0;
        req0_dividend = 4'd9; req0_divisor = 4'd1; req0_valid = 1'b1;
        wait_acc(n_acc + 1);
        req0_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        s0 = n_starts; v0 = n_rv;
        repeat (5) step();
        chk("rst_no_start", 32'(n_starts - s0), 0);
        chk("rst_no_rsp", 32'(n_rv - v0), 0);

        // both requesting continuously right after reset
        div_lat = 1; rsp_ready = 1'b1;
        gid_q.delete();
        a0 = n_acc; r0 = n_rsp;
        req0_dividend = 4'd7; req0_divisor = 4'd3;
        req1_dividend = 4'd0; req1_divisor = 4'd1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_acc(a0 + 4);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(r0 + 4);
        if (gid_q.size() >= 4) begin
            chk("rr_g0", 32'(gid_q[0]), 0);
            chk("rr_g1", 32'(gid_q[1]), 1);
            chk("rr_g2", 32'(gid_q[2]), 0);
            chk("rr_g3", 32'(gid_q[3]), 1);
        end else tmo("rr_grants");
        chk("rr_last_id", 32'(l_id), 1);
        chk("rr_req1_q", 32'(l_q), 0);
        chk("rr_req1_r", 32'(l_r), 0);

        run_one(0, 4'd15, 4'd15, 2);
        chk("ff_q", 32'(l_q), 1);
        chk("ff_r", 32'(l_r), 0);
        chk("ff_err", 32'(l_err), 0);

        // randomized traffic
        spur_en = 1;
        p0 = n_hs0; p1 = n_hs1;
        for (int c = 0; c < 600; c++) begin
            if (n_hs0 != p0) begin req0_valid = 1'b0; p0 = n_hs0; end
            if (n_hs1 != p1) begin req1_valid = 1'b0; p1 = n_hs1; end
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1'b1;
                req0_dividend = W'($urandom);
                req0_divisor = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1'b1;
                req1_dividend = W'($urandom);
                req1_divisor = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            div_lat = $urandom_range(0, 17);
            step();
        end
        spur_en = 0;
        if (n_hs0 != p0) req0_valid = 1'b0;
        if (n_hs1 != p1) req1_valid = 1'b0;
        rsp_ready = 1'b1; div_lat = 1;
        repeat (60) begin
            if (n_hs0 != p0) begin req0_valid = 1'b0; p0 = n_hs0; end
            if (n_hs1 != p1) begin req1_valid = 1'b0; p1 = n_hs1; end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
